receiver: RTL and testbench
===========================

# receiver

UART receive stage that recovers bytes from a serial line carrying frames in the format produced by our sender. The frame is 1 start bit (0), 8 data bits LSB first, an optional parity bit and 1 stop bit (1). The block oversamples the line, checks start, parity and stop bits, and presents each byte with a one-cycle valid strobe and error flags. It sits at the RX pin, directly downstream of the serial link, and feeds the byte consumer.

## Interface
- OVERSAMPLE, 16: CLK cycles per bit period; must be even and ≥ 4.
- PARITY, 1: 1 = odd (the default framing on our link), 2 = even, 0 = no parity bit.
- CLK  in  1  clock, f = OVERSAMPLE × baud rate.
- rst_n  in  1  reset, asynchronous assert, active low.
- RX  in  1  serial line, asynchronous to CLK, idles high.
- message  out  [8:1]  received data byte; message[1] is the first data bit on the line.
- valid  out  1  one-cycle strobe; message, parity_err and frame_err are updated on this cycle.
- parity_err  out  1  parity mismatch on the last frame; always 0 when PARITY = 0.
- frame_err  out  1  stop bit sampled as 0 on the last frame.
- busy  out  1  high in every state except IDLE.

## Operation
- RX passes through a 2-flop synchronizer (rx_s). Both flops reset to 1.
- There is a bit-phase counter cnt (0..OVERSAMPLE-1), a bit index idx (0..7) and an internal shift register.
- The state machine is IDLE, START, DATA, PAR, STOP, BREAK.
- IDLE: when rx_s = 0, go to START with cnt = 0.
- START: when cnt = OVERSAMPLE/2 - 1, sample rx_s. This is mid start bit.
  - rx_s = 0: go to DATA with cnt = 0, idx = 0.
  - rx_s = 1 (glitch or false start): go back to IDLE. No valid pulse, no flag change.
- DATA: when cnt = OVERSAMPLE - 1, sample rx_s into bit idx+1 and reset cnt to 0.
  - After idx = 7, go to PAR if PARITY ≠ 0, otherwise go to STOP.
- PAR: when cnt = OVERSAMPLE - 1, capture the parity bit p and go to STOP.
  - Odd: error if (^data ^ p) = 0.
  - Even: error if (^data ^ p) = 1.
- STOP: when cnt = OVERSAMPLE - 1, sample rx_s.
  - On that cycle, load message, parity_err and frame_err (= ~rx_s), and pulse valid.
  - rx_s = 1: go to IDLE.
  - rx_s = 0: go to BREAK.
- BREAK: wait until rx_s = 1, then go to IDLE. This prevents a held-low line from re-triggering.
- Output holding:
  - message, parity_err and frame_err hold their values between valid pulses.
  - A frame with errors still delivers its byte, with the flags set.
- Reset:
  - rst_n low at any time, including mid-frame, forces state IDLE, cnt = 0 and idx = 0.
  - It also forces message = 8'h00, valid = 0, parity_err = 0, frame_err = 0, busy = 0 and the synchronizer flops to 1.
  - A partially received frame is discarded.
- No backpressure. The consumer must take the byte on the valid cycle. The next frame overwrites message.

## Timing
- Let E be the first posedge at which IDLE sees rx_s = 0. rx_s lags the RX pin by 2 CLK cycles.
- With OVERSAMPLE = 16:
  - Start sample at E+8.
  - Data bit k (k = 1..8) sampled at E+8+16k.
  - Parity sample at E+152.
  - Stop sample at E+168. With PARITY = 0 it is at E+152.
- valid is high for exactly the one cycle following the stop-sample edge. Outputs are registered and change on that edge.
- busy rises the cycle after E. It falls at the stop-sample edge when the stop bit is 1.
- Back-to-back frames: the sender's next start bit begins half a bit after the stop sample. IDLE is re-entered first, so no frame is lost.
- Tolerated baud mismatch between transmitter and CLK/OVERSAMPLE: ±3% over an 11-bit frame.

## Test plan
- Odd parity, byte 8'hA5 (four ones, so p = 1): frame 0,1,0,1,0,0,1,0,1,1,1 at 16 CLK per bit. Expect one valid pulse, message = 8'hA5, parity_err = 0, frame_err = 0, at E+169.
- Same frame with p flipped to 0: message = 8'hA5, parity_err = 1, frame_err = 0.
- Byte 8'h3C with the stop bit driven 0 and the line held low for 40 more bits: frame_err = 1. busy stays high until RX returns high. Exactly one valid pulse, no re-trigger.
- RX low pulse of 5 CLK cycles in IDLE: no valid, busy returns to 0 within 8 cycles of E, outputs unchanged.
- Two back-to-back frames, 8'h00 then 8'hFF, with no idle gap: two valid pulses 176 cycles apart, correct bytes, no errors.
- rst_n pulsed low during data bit 4 of a frame: all outputs return to reset values asynchronously. The next clean frame, 8'h5A, is received correctly.

Source files
------------

// File: rtl/receiver.sv
// UART receiver: oversampled start/data/parity/stop recovery; valid strobes one cycle after the stop sample.
// No backpressure: message and flags are overwritten by the next frame.
module receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 1
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       RX,
  output logic [8:1] message,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          rx_m;
  logic          rx_s;

  // RX is asynchronous to CLK; idle-high reset keeps a false start from firing out of reset.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      message    <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) begin
              idx   <= '0;
              state <= (PARITY != 0) ? PAR : STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PAR: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            par_bad <= (PARITY == 2) ? (^shreg ^ rx_s) : ~(^shreg ^ rx_s);
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            message    <= shreg;
            valid      <= 1'b1;
            parity_err <= (PARITY != 0) && par_bad;
            frame_err  <= ~rx_s;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // Held-low line: wait for it to return high so it cannot look like a new start bit.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: odd parity, 16 CLK per bit, frames driven on falling edges.
module tb_receiver;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       RX;
  logic [8:1] message;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  receiver #(.OVERSAMPLE(16), .PARITY(1)) dut (
    .CLK(CLK), .rst_n(rst_n), .RX(RX), .message(message), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Valid pulse monitor: counts strobes and records the posedge count they followed.
  int vcount = 0;
  int last_vcyc = 0;
  always @(negedge CLK) begin
    if (valid === 1'b1) begin
      vcount++;
      last_vcyc = cyc;
    end
  end

  int npass = 0;
  int ntot = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic bitcell(input logic b);
    RX = b;
    repeat (16) @(negedge CLK);
  endtask

  task automatic frame(input logic [7:0] d, input logic p, input logic stp, output int c0);
    c0 = cyc;
    bitcell(1'b0);
    for (int i = 0; i < 8; i++) bitcell(d[i]);
    bitcell(p);
    bitcell(stp);
  endtask

  int c0;
  int v1;
  logic [7:0] rb;

  initial begin
    rst_n = 1'b0;
    RX    = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_message", 32'(message), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(negedge CLK);
    bitcell(1'b1);

    // Clean A5 with correct odd parity
    frame(8'hA5, 1'b1, 1'b1, c0);
    chk("a5_vcount", 32'(vcount), 32'd1);
    chk("a5_valid_cycle", 32'(last_vcyc), 32'(c0 + 171));
    chk("a5_message", 32'(message), 32'hA5);
    chk("a5_parity_err", 32'(parity_err), 32'h0);
    chk("a5_frame_err", 32'(frame_err), 32'h0);
    chk("a5_busy_after", 32'(busy), 32'h0);

    // Same byte with parity bit flipped
    frame(8'hA5, 1'b0, 1'b1, c0);
    chk("a5p_vcount", 32'(vcount), 32'd2);
    chk("a5p_message", 32'(message), 32'hA5);
    chk("a5p_parity_err", 32'(parity_err), 32'h1);
    chk("a5p_frame_err", 32'(frame_err), 32'h0);

    // 3C with a zero stop bit and the line held low for 40 more bits
    frame(8'h3C, 1'b1, 1'b0, c0);
    repeat (40) bitcell(1'b0);
    chk("brk_busy_low_line", 32'(busy), 32'h1);
    chk("brk_vcount_held", 32'(vcount), 32'd3);
    chk("brk_frame_err", 32'(frame_err), 32'h1);
    bitcell(1'b1);
    chk("brk_busy_released", 32'(busy), 32'h0);
    chk("brk_vcount_final", 32'(vcount), 32'd3);
    chk("brk_message", 32'(message), 32'h3C);
    chk("brk_parity_err", 32'(parity_err), 32'h0);

    // 5-cycle low glitch in IDLE: E = c0+3, rejected at E+8
    c0 = cyc;
    RX = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      if (k == 5) RX = 1'b1;
      if (k == 2) chk("glitch_busy_before_e", 32'(busy), 32'h0);
      if (k == 3) chk("glitch_busy_after_e", 32'(busy), 32'h1);
      if (k == 10) chk("glitch_busy_in_start", 32'(busy), 32'h1);
      if (k == 11) chk("glitch_busy_dropped", 32'(busy), 32'h0);
    end
    chk("glitch_vcount", 32'(vcount), 32'd3);
    chk("glitch_message", 32'(message), 32'h3C);
    chk("glitch_frame_err", 32'(frame_err), 32'h1);
    bitcell(1'b1);

    // Back-to-back 00 then FF, no idle gap
    frame(8'h00, 1'b1, 1'b1, c0);
    v1 = last_vcyc;
    chk("b2b_first_cycle", 32'(v1), 32'(c0 + 171));
    chk("b2b_first_message", 32'(message), 32'h00);
    chk("b2b_first_frame_err", 32'(frame_err), 32'h0);
    frame(8'hFF, 1'b1, 1'b1, c0);
    chk("b2b_spacing", 32'(last_vcyc - v1), 32'd176);
    chk("b2b_vcount", 32'(vcount), 32'd5);
    chk("b2b_second_message", 32'(message), 32'hFF);
    chk("b2b_parity_err", 32'(parity_err), 32'h0);
    chk("b2b_frame_err", 32'(frame_err), 32'h0);

    // Reset pulse midway through data bit 4
    rb = 8'hA5;
    bitcell(1'b0);
    for (int i = 0; i < 3; i++) bitcell(rb[i]);
    RX = rb[3];
    repeat (8) @(negedge CLK);
    chk("mid_busy_before_rst", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #2;
    chk("async_rst_message", 32'(message), 32'h00);
    chk("async_rst_valid", 32'(valid), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_parity_err", 32'(parity_err), 32'h0);
    chk("async_rst_frame_err", 32'(frame_err), 32'h0);
    RX = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
    bitcell(1'b1);
    bitcell(1'b1);
    chk("post_rst_no_valid", 32'(vcount), 32'd5);
    frame(8'h5A, 1'b1, 1'b1, c0);
    chk("5a_vcount", 32'(vcount), 32'd6);
    chk("5a_valid_cycle", 32'(last_vcyc), 32'(c0 + 171));
    chk("5a_message", 32'(message), 32'h5A);
    chk("5a_parity_err", 32'(parity_err), 32'h0);
    chk("5a_frame_err", 32'(frame_err), 32'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
